fft_output_reorder: RTL

//  Downstream stage of fft_top. Unloads the engine's result RAM after FFT_DONE
//  and reads it in bit-reversed address order, so samples leave in natural order.

---
 rtl/fft_output_reorder.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_output_reorder.sv
// rtl/fft_output_reorder.sv - unloads the FFT result RAM in bit-reversed order as a natural-order sample stream
// Optional feature macro: FFT_OUT_DENORM_EN (saturating scale-up stage and sat_count_o).
module fft_output_reorder #(
    parameter int FFT_MAX_LENGTH_LOG2 = 12,
    parameter int DATA_WIDTH          = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           start_i,
    input  logic [3:0]                     length_log2_i,
    input  logic [7:0]                     scale_factor_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           error_o,
    output logic                           mem_rd_en_o,
    output logic [FFT_MAX_LENGTH_LOG2-1:0] mem_rd_addr_o,
    input  logic [2*DATA_WIDTH-1:0]        mem_rd_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [DATA_WIDTH-1:0]          out_real_o,
    output logic [DATA_WIDTH-1:0]          out_imag_o,
    output logic [FFT_MAX_LENGTH_LOG2-1:0] out_index_o,
    output logic                           out_last_o,
    output logic [7:0]                     sat_count_o
);

    localparam int AW = FFT_MAX_LENGTH_LOG2;
    localparam int DW = DATA_WIDTH;
    localparam logic [3:0] LEN_MAX = 4'(AW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]      r_len;
    logic [AW-1:0]   r_last_k;
    logic [AW-1:0]   r_k;
    logic [AW-1:0]   r_out_k;
    logic            r_done;
    logic            r_error;
    logic            r_rd_pend;

    logic [2*DW-1:0] r_buf [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;

    logic            w_len_ok;
    logic            w_start_ok;
    logic            w_start_bad;
    logic            w_rd_en;
    logic            w_pop;
    logic            w_push;
    logic            w_fifo_pop;
    logic            w_fifo_empty;
    logic            w_in_valid;
    logic [2*DW-1:0] w_in_data;
    logic [2*DW-1:0] w_head;
    logic [1:0]      w_inflight;
    logic [2:0]      w_outstanding;
    logic [AW-1:0]   w_rev;

    assign w_len_ok    = (length_log2_i != 4'd0) && (length_log2_i <= LEN_MAX);
    assign w_start_ok  = (r_state == S_IDLE) && start_i && w_len_ok;
    assign w_start_bad = (r_state == S_IDLE) && start_i && !w_len_ok;

    // Samples owed downstream; counting this cycle's transfer as gone keeps 1 sample/clk.
    assign w_outstanding = {1'b0, r_count} + {1'b0, w_inflight};
    assign w_rd_en       = (r_state == S_RUN) &&
                           ((w_outstanding - {2'b00, w_pop}) < 3'd2);

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < AW; i++) begin
            w_rev[i] = r_k[AW-1-i];
        end
    end

    assign mem_rd_en_o   = w_rd_en;
    assign mem_rd_addr_o = w_rd_en ? (w_rev >> (LEN_MAX - r_len)) : '0;

`ifdef FFT_OUT_DENORM_EN
    localparam logic signed [2*DW-1:0] W_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW-1:0] W_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [7:0]      r_scale;
    logic            r_s_valid;
    logic [2*DW-1:0] r_s_data;
    logic [7:0]      r_sat_count;
    logic [DW:0]     w_re_sat;
    logic [DW:0]     w_im_sat;
    logic [8:0]      w_sat_sum;

    // Returns {clamped, value}; the 2*DW-bit product cannot overflow for shifts up to DW.
    function automatic logic [DW:0] sat_shift(input logic [DW-1:0] x, input logic [7:0] sc);
        logic signed [2*DW-1:0] ext;
        logic signed [2*DW-1:0] shifted;
        int                     sh;
        sh      = (int'(sc) > DW) ? DW : int'(sc);
        ext     = signed'({{DW{x[DW-1]}}, x});
        shifted = ext <<< sh;
        if (shifted > W_MAX) begin
            return {1'b1, W_MAX[DW-1:0]};
        end
        if (shifted < W_MIN) begin
            return {1'b1, W_MIN[DW-1:0]};
        end
        return {1'b0, shifted[DW-1:0]};
    endfunction

    assign w_re_sat  = sat_shift(mem_rd_data_i[2*DW-1:DW], r_scale);
    assign w_im_sat  = sat_shift(mem_rd_data_i[DW-1:0], r_scale);
    assign w_sat_sum = {1'b0, r_sat_count} + 9'(w_re_sat[DW]) + 9'(w_im_sat[DW]);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_scale     <= '0;
            r_s_valid   <= 1'b0;
            r_s_data    <= '0;
            r_sat_count <= '0;
        end else begin
            r_s_valid <= r_rd_pend;
            if (w_start_ok) begin
                r_scale     <= scale_factor_i;
                r_sat_count <= '0;
            end else if (r_rd_pend) begin
                r_sat_count <= w_sat_sum[8] ? 8'hFF : w_sat_sum[7:0];
            end
            if (r_rd_pend) begin
                r_s_data <= {w_re_sat[DW-1:0], w_im_sat[DW-1:0]};
            end
        end
    end

    assign w_in_valid  = r_s_valid;
    assign w_in_data   = r_s_data;
    assign w_inflight  = {1'b0, r_rd_pend} + {1'b0, r_s_valid};
    assign sat_count_o = r_sat_count;
`else
    logic w_unused_scale;

    assign w_unused_scale = ^scale_factor_i;
    assign w_in_valid     = r_rd_pend;
    assign w_in_data      = mem_rd_data_i;
    assign w_inflight     = {1'b0, r_rd_pend};
    assign sat_count_o    = '0;
`endif

    // Fall-through buffer: an empty buffer presents arriving data directly.
    assign w_fifo_empty = (r_count == 2'd0);
    assign w_head       = w_fifo_empty ? w_in_data : r_buf[r_rd_ptr];
    assign out_valid_o  = !w_fifo_empty || w_in_valid;
    assign w_pop        = out_valid_o && out_ready_i;
    assign w_push       = w_in_valid && !(w_fifo_empty && out_ready_i);
    assign w_fifo_pop   = !w_fifo_empty && out_ready_i;

    assign out_real_o  = out_valid_o ? w_head[2*DW-1:DW] : '0;
    assign out_imag_o  = out_valid_o ? w_head[DW-1:0] : '0;
    assign out_index_o = out_valid_o ? r_out_k : '0;
    assign out_last_o  = out_valid_o && (r_out_k == r_last_k);

    assign busy_o  = (r_state != S_IDLE);
    assign done_o  = r_done;
    assign error_o = r_error;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_rd_en && (r_k == r_last_k)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && out_last_o) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_len     <= '0;
            r_last_k  <= '0;
            r_k       <= '0;
            r_out_k   <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            r_done    <= (r_state == S_DRAIN) && w_pop && out_last_o;
            r_error   <= w_start_bad;
            r_rd_pend <= w_rd_en;
            if (w_start_ok) begin
                r_len    <= length_log2_i;
                r_last_k <= ~({AW{1'b1}} << length_log2_i);
                r_k      <= '0;
                r_out_k  <= '0;
            end else begin
                if (w_rd_en) begin
                    r_k <= r_k + 1'b1;
                end
                if (w_pop) begin
                    r_out_k <= r_out_k + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 2; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_buf[r_wr_ptr] <= w_in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
        end
    end

endmodule
